// File: rtl/switch_conn_ctrl_if.sv
// Handshake bundle between the connection controller and its neighbours
// (input port FIFOs, all-or-nothing arbiter, crossbar mux / output ports).
// master: the controller side. slave: the surrounding switch datapath.
// Signals:
//   in_valid/in_dst/in_len : head-of-line packet per input port (FIFO -> ctrl)
//   in_pop                 : one beat consumed from input port i (ctrl -> FIFO)
//   arb_req/arb_dst        : request + destination mask per input (ctrl -> arb)
//   arb_grant              : same-cycle grant from arbiter (arb -> ctrl)
//   out_ready              : output port can take a beat (output -> ctrl)
//   out_valid/out_sel      : beat strobe and mux select per output (ctrl -> xbar)
//   out_busy/xfer_active/starve : status
interface switch_conn_ctrl_if #(
  parameter int LEN_W = 8
);
  logic [3:0]            in_valid;
  logic [3:0][3:0]       in_dst;
  logic [3:0][LEN_W-1:0] in_len;
  logic [3:0]            in_pop;
  logic [3:0]            arb_req;
  logic [3:0][3:0]       arb_dst;
  logic [3:0]            arb_grant;
  logic [3:0]            out_ready;
  logic [3:0]            out_valid;
  logic [3:0][1:0]       out_sel;
  logic [3:0]            out_busy;
  logic [3:0]            xfer_active;
  logic [3:0]            starve;

  modport master (
    input  in_valid, in_dst, in_len, arb_grant, out_ready,
    output in_pop, arb_req, arb_dst, out_valid, out_sel, out_busy,
           xfer_active, starve
  );

  modport slave (
    output in_valid, in_dst, in_len, arb_grant, out_ready,
    input  in_pop, arb_req, arb_dst, out_valid, out_sel, out_busy,
           xfer_active, starve
  );
endinterface

// File: rtl/switch_conn_ctrl.sv
// Connection controller: locks crossbar outputs for whole multi-beat packets,
// presents head-of-line requests to the arbiter and prevents multicast starvation.
// Latency: grant taken at edge T, lock visible and first beat possible in T+1.
// Backpressure: a port pops only when every output it holds has out_ready
// (all-or-nothing multicast); beats stall otherwise.
// Ports: clk, rst_n (async active-low), bus (switch_conn_ctrl_if.master).
module switch_conn_ctrl #(
  parameter int LEN_W    = 8,
  parameter int MAX_WAIT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  switch_conn_ctrl_if.master bus
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_XFER = 2'd2
  } state_e;

  state_e           st_q    [4];
  logic [LEN_W-1:0] cnt_q   [4];
  logic [WW-1:0]    wait_q  [4];
  logic [3:0]       busy_q, busy_d;
  logic [1:0]       owner_q [4];
  logic [1:0]       owner_d [4];

  logic [3:0] lock_mask [4];
  logic [3:0] starve_w;
  logic [3:0] elig_w;
  logic [3:0] pop_w;
  logic [3:0] done_w;
  logic [3:0] gnt_ok_w;
  logic [3:0] claim_w;
  logic       res_vld_w;
  logic [1:0] res_idx_w;
  logic [3:0] res_mask_w;

  always_comb begin
    starve_w   = '0;
    elig_w     = '0;
    pop_w      = '0;
    done_w     = '0;
    gnt_ok_w   = '0;
    claim_w    = '0;
    res_vld_w  = 1'b0;
    res_idx_w  = '0;
    res_mask_w = '0;
    busy_d     = busy_q;
    for (int i = 0; i < 4; i++) begin
      owner_d[i]   = owner_q[i];
      lock_mask[i] = '0;
    end

    // Outputs currently held by each input (empty for a discarded dst=0 packet).
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        lock_mask[i][j] = busy_q[j] && (owner_q[j] == 2'(i));
      end
      starve_w[i] = (wait_q[i] == WW'(MAX_WAIT));
    end

    // Lowest-index starving port reserves its destination set; scanning
    // downwards leaves the lowest index as the final winner.
    for (int i = 3; i >= 0; i--) begin
      if (starve_w[i]) begin
        res_vld_w  = 1'b1;
        res_idx_w  = 2'(i);
        res_mask_w = bus.in_dst[i];
      end
    end

    for (int i = 0; i < 4; i++) begin
      elig_w[i] = rst_n && bus.in_valid[i] && (st_q[i] != ST_XFER)
               && (bus.in_dst[i] != 4'b0)
               && ((bus.in_dst[i] & busy_q) == 4'b0)
               && !(res_vld_w && (res_idx_w != 2'(i))
                    && ((bus.in_dst[i] & res_mask_w) != 4'b0));
      // All held outputs must be ready; an empty mask pops unconditionally.
      pop_w[i]  = (st_q[i] == ST_XFER)
               && ((bus.out_ready | ~lock_mask[i]) == 4'hF);
      done_w[i] = pop_w[i] && (cnt_q[i] == LEN_W'(1));
    end

    // Grants to ineligible ports, or overlapping a lower-index grant taken
    // this cycle, are dropped so an output can never get two owners.
    for (int i = 0; i < 4; i++) begin
      gnt_ok_w[i] = bus.arb_grant[i] && elig_w[i]
                 && ((bus.in_dst[i] & claim_w) == 4'b0);
      if (gnt_ok_w[i]) claim_w = claim_w | bus.in_dst[i];
    end

    for (int i = 0; i < 4; i++) begin
      if (done_w[i]) busy_d = busy_d & ~lock_mask[i];
    end
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (gnt_ok_w[i] && bus.in_dst[i][j]) begin
          busy_d[j]  = 1'b1;
          owner_d[j] = 2'(i);
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      bus.arb_dst[i]     = elig_w[i] ? bus.in_dst[i] : 4'b0;
      bus.out_sel[i]     = owner_q[i];
      bus.out_valid[i]   = busy_q[i] && pop_w[owner_q[i]];
      bus.xfer_active[i] = (st_q[i] == ST_XFER);
    end
  end

  assign bus.in_pop   = pop_w;
  assign bus.arb_req  = elig_w;
  assign bus.out_busy = busy_q;
  assign bus.starve   = starve_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      for (int i = 0; i < 4; i++) begin
        st_q[i]    <= ST_IDLE;
        cnt_q[i]   <= '0;
        wait_q[i]  <= '0;
        owner_q[i] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      for (int i = 0; i < 4; i++) begin
        owner_q[i] <= owner_d[i];
        case (st_q[i])
          ST_XFER: begin
            if (pop_w[i]) begin
              if (cnt_q[i] == LEN_W'(1)) begin
                st_q[i]  <= ST_IDLE;
                cnt_q[i] <= '0;
              end else begin
                cnt_q[i] <= cnt_q[i] - LEN_W'(1);
              end
            end
          end
          default: begin
            // dst=0 packets skip arbitration and drain with no outputs locked.
            if ((bus.in_valid[i] && (bus.in_dst[i] == 4'b0)) || gnt_ok_w[i]) begin
              st_q[i]   <= ST_XFER;
              cnt_q[i]  <= (bus.in_len[i] == '0) ? LEN_W'(1) : bus.in_len[i];
              wait_q[i] <= '0;
            end else if (bus.in_valid[i]) begin
              st_q[i] <= ST_WAIT;
              if (wait_q[i] != WW'(MAX_WAIT)) wait_q[i] <= wait_q[i] + WW'(1);
            end else begin
              st_q[i]   <= ST_IDLE;
              wait_q[i] <= '0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_switch_conn_ctrl.sv
module tb_switch_conn_ctrl;
  localparam int LEN_W = 8;
  localparam int MW    = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  switch_conn_ctrl_if #(.LEN_W(LEN_W)) bus ();

  switch_conn_ctrl #(.LEN_W(LEN_W), .MAX_WAIT(MW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Connection-level model: one entry per input describing its open connection.
  int         conn_left  [4];
  logic [3:0] conn_mask  [4];
  int         waited     [4];
  logic [1:0] last_owner [4];

  // Head-of-line sources.
  logic             src_vld [4];
  logic [3:0]       src_dst [4];
  logic [LEN_W-1:0] src_len [4];
  bit               refill  [4];
  bit               rnd_mode;

  logic [3:0] rdy;
  logic [3:0] grant_allow;
  logic [3:0] spur;
  logic       rst_req;
  int         rr_ptr;

  logic [3:0] cap_pop, cap_req, cap_valid, cap_busy, cap_xfer, cap_starve;
  logic [3:0] cap_dst [4];
  logic [1:0] cap_sel [4];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic new_pkt(input int i);
    src_vld[i] = 1'b1;
    src_dst[i] = ($urandom_range(0, 9) == 0) ? 4'b0 : 4'($urandom_range(1, 15));
    src_len[i] = LEN_W'($urandom_range(0, 6));
  endtask

  task automatic set_src(input int i, input logic [3:0] d, input int len);
    src_vld[i] = 1'b1;
    src_dst[i] = d;
    src_len[i] = LEN_W'(len);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      conn_left[i]  = 0;
      conn_mask[i]  = '0;
      waited[i]     = 0;
      last_owner[i] = '0;
    end
  endtask

  // One clock cycle: drive at the falling edge, check the model 1 time unit later,
  // then advance the model to what the next rising edge must produce.
  task automatic step();
    logic [3:0] busy_e, req_e, pop_e, val_e, xfer_e, starve_e, gnt, claimed;
    logic [3:0] dst_e [4];
    bit         fin   [4];
    int         s, last_g, idx;
    @(negedge clk);
    cyc++;
    rst_n = rst_req;
    if (!rst_n) model_reset();
    for (int i = 0; i < 4; i++) begin
      bus.in_valid[i] = src_vld[i];
      bus.in_dst[i]   = src_dst[i];
      bus.in_len[i]   = src_len[i];
    end
    bus.out_ready = rdy;

    busy_e = '0;
    for (int i = 0; i < 4; i++)
      if (conn_left[i] > 0) busy_e = busy_e | conn_mask[i];
    s = -1;
    for (int i = 3; i >= 0; i--) begin
      starve_e[i] = (waited[i] >= MW);
      if (starve_e[i]) s = i;
    end
    for (int i = 0; i < 4; i++) begin
      req_e[i] = rst_n && src_vld[i] && conn_left[i] == 0 && src_dst[i] != 0
              && (src_dst[i] & busy_e) == 0
              && !(s >= 0 && s != i && (src_dst[i] & src_dst[s]) != 0);
      dst_e[i] = req_e[i] ? src_dst[i] : 4'b0;
      pop_e[i] = (conn_left[i] > 0) && ((conn_mask[i] & ~rdy) == 0);
      xfer_e[i] = (conn_left[i] > 0);
    end
    for (int j = 0; j < 4; j++) val_e[j] = busy_e[j] && pop_e[last_owner[j]];

    // Round-robin all-or-nothing arbiter standing in for the real one.
    gnt = '0; claimed = '0; last_g = -1;
    for (int k = 0; k < 4; k++) begin
      idx = (rr_ptr + k) % 4;
      if (req_e[idx] && grant_allow[idx] && (src_dst[idx] & claimed) == 0) begin
        gnt[idx] = 1'b1;
        claimed = claimed | src_dst[idx];
        last_g = idx;
      end
    end
    if (last_g >= 0) rr_ptr = (last_g + 1) % 4;
    gnt = gnt | (spur & ~req_e);
    bus.arb_grant = gnt;
    #1;

    cap_pop = bus.in_pop; cap_req = bus.arb_req; cap_valid = bus.out_valid;
    cap_busy = bus.out_busy; cap_xfer = bus.xfer_active; cap_starve = bus.starve;
    for (int i = 0; i < 4; i++) begin
      cap_dst[i] = bus.arb_dst[i];
      cap_sel[i] = bus.out_sel[i];
    end
    chk("in_pop", 8'(cap_pop), 8'(pop_e));
    chk("arb_req", 8'(cap_req), 8'(req_e));
    chk("out_valid", 8'(cap_valid), 8'(val_e));
    chk("out_busy", 8'(cap_busy), 8'(busy_e));
    chk("xfer_active", 8'(cap_xfer), 8'(xfer_e));
    chk("starve", 8'(cap_starve), 8'(starve_e));
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("arb_dst%0d", i), 8'(cap_dst[i]), 8'(dst_e[i]));
      chk($sformatf("out_sel%0d", i), 8'(cap_sel[i]), 8'(last_owner[i]));
    end

    if (!rst_n) return;
    claimed = '0;
    for (int i = 0; i < 4; i++) begin
      fin[i] = 0;
      if (conn_left[i] > 0) begin
        if (pop_e[i]) begin
          conn_left[i]--;
          fin[i] = (conn_left[i] == 0);
        end
      end else if (src_vld[i] && src_dst[i] == 0) begin
        conn_left[i] = (src_len[i] == 0) ? 1 : int'(src_len[i]);
        conn_mask[i] = '0;
        waited[i]    = 0;
      end else if (gnt[i] && req_e[i] && (src_dst[i] & claimed) == 0) begin
        claimed      = claimed | src_dst[i];
        conn_left[i] = (src_len[i] == 0) ? 1 : int'(src_len[i]);
        conn_mask[i] = src_dst[i];
        for (int j = 0; j < 4; j++) if (src_dst[i][j]) last_owner[j] = 2'(i);
        waited[i] = 0;
      end else if (src_vld[i]) begin
        waited[i] = (waited[i] + 1 > MW) ? MW : waited[i] + 1;
      end else begin
        waited[i] = 0;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (fin[i]) src_vld[i] = refill[i];
      if (rnd_mode && conn_left[i] == 0) begin
        if (!src_vld[i]) begin
          if ($urandom_range(0, 2) == 0) new_pkt(i);
        end else if (!fin[i] && $urandom_range(0, 39) == 0) begin
          src_vld[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic drain();
    int pending;
    rnd_mode = 0; rdy = 4'hF; grant_allow = 4'hF; spur = '0; rst_req = 1'b1;
    for (int i = 0; i < 4; i++) refill[i] = 0;
    pending = 1;
    for (int k = 0; k < 300 && pending != 0; k++) begin
      step();
      pending = 0;
      for (int i = 0; i < 4; i++) if (src_vld[i] || conn_left[i] > 0) pending++;
    end
    chk("drain_pending", 8'(pending), 8'd0);
  endtask

  initial begin
    rst_n = 1'b0; rst_req = 1'b0; rnd_mode = 0; rr_ptr = 0;
    rdy = 4'hF; grant_allow = 4'hF; spur = '0;
    for (int i = 0; i < 4; i++) begin
      src_vld[i] = 1'b0; src_dst[i] = '0; src_len[i] = '0; refill[i] = 0;
      bus.in_dst[i] = 4'hF; bus.in_len[i] = LEN_W'(3);
    end
    model_reset();
    bus.in_valid = 4'hF; bus.out_ready = 4'hF; bus.arb_grant = 4'hF;
    #3;
    // Reset state, with every input trying to provoke a request.
    chk("rst_arb_req", 8'(bus.arb_req), 8'd0);
    chk("rst_arb_dst0", 8'(bus.arb_dst[0]), 8'd0);
    chk("rst_in_pop", 8'(bus.in_pop), 8'd0);
    chk("rst_out_busy", 8'(bus.out_busy), 8'd0);
    chk("rst_out_valid", 8'(bus.out_valid), 8'd0);
    chk("rst_out_sel3", 8'(bus.out_sel[3]), 8'd0);
    chk("rst_xfer", 8'(bus.xfer_active), 8'd0);
    chk("rst_starve", 8'(bus.starve), 8'd0);
    step(); step();
    rst_req = 1'b1;
    step();

    // Unicast port0 -> output1, 3 beats.
    set_src(0, 4'b0010, 3);
    step();
    chk("uni_req", 8'(cap_req), 8'b0001);
    chk("uni_dst0", 8'(cap_dst[0]), 8'b0010);
    for (int c = 1; c <= 3; c++) begin
      step();
      chk("uni_busy", 8'(cap_busy), 8'b0010);
      chk("uni_sel1", 8'(cap_sel[1]), 8'd0);
      chk("uni_pop", 8'(cap_pop), 8'b0001);
      chk("uni_valid", 8'(cap_valid), 8'b0010);
    end
    step();
    chk("uni_free", 8'(cap_busy), 8'b0000);
    drain();

    // Multicast port2 -> outputs 1,3 with output 3 stalled two cycles.
    set_src(2, 4'b1010, 2);
    step();
    chk("mc_req", 8'(cap_req), 8'b0100);
    rdy = 4'b0111;
    for (int c = 1; c <= 2; c++) begin
      step();
      chk("mc_stall_pop", 8'(cap_pop), 8'b0000);
      chk("mc_stall_valid", 8'(cap_valid), 8'b0000);
    end
    rdy = 4'hF;
    for (int c = 3; c <= 4; c++) begin
      step();
      chk("mc_pop", 8'(cap_pop), 8'b0100);
      chk("mc_valid", 8'(cap_valid), 8'b1010);
    end
    step();
    chk("mc_free", 8'(cap_busy), 8'b0000);
    drain();

    // Busy masking: port3 waits on output1 held by port1.
    set_src(1, 4'b0010, 4);
    step();
    set_src(3, 4'b0010, 1);
    for (int c = 1; c <= 4; c++) begin
      step();
      chk("mask_dst3", 8'(cap_dst[3]), 8'd0);
      chk("mask_sel1", 8'(cap_sel[1]), 8'd1);
    end
    step();
    chk("mask_req", 8'(cap_req), 8'b1000);
    chk("mask_dst3_free", 8'(cap_dst[3]), 8'b0010);
    step();
    chk("mask_busy", 8'(cap_busy), 8'b0010);
    chk("mask_sel1_new", 8'(cap_sel[1]), 8'd3);
    drain();

    // Starvation of a broadcast request behind continuous unicast traffic.
    refill[1] = 1; refill[2] = 1; refill[3] = 1;
    set_src(1, 4'b0010, 3); set_src(2, 4'b0100, 4); set_src(3, 4'b1000, 5);
    step();
    set_src(0, 4'b1111, 2);
    for (int c = 0; c <= 2; c++) step();
    step();
    chk("stv_c3_starve", 8'(cap_starve), 8'b0000);
    chk("stv_c3_req", 8'(cap_req), 8'b0010);
    for (int c = 4; c <= 6; c++) begin
      step();
      chk("stv_starve0", 8'(cap_starve[0]), 8'd1);
      chk("stv_blocked", 8'(cap_req & 4'b1110), 8'd0);
    end
    step();
    chk("stv_req0", 8'(cap_req), 8'b0001);
    chk("stv_dst0", 8'(cap_dst[0]), 8'b1111);
    step();
    chk("stv_busy", 8'(cap_busy), 8'b1111);
    chk("stv_starve_clr", 8'(cap_starve[0]), 8'd0);
    drain();

    // dst=0 discard, 5 beats.
    set_src(0, 4'b0000, 5);
    step();
    chk("d0_req", 8'(cap_req), 8'd0);
    for (int c = 1; c <= 5; c++) begin
      step();
      chk("d0_pop", 8'(cap_pop), 8'b0001);
      chk("d0_valid", 8'(cap_valid), 8'd0);
      chk("d0_req", 8'(cap_req), 8'd0);
    end
    step();
    chk("d0_done", 8'(cap_pop), 8'd0);
    drain();

    // Reset in the middle of a 4-beat transfer.
    set_src(0, 4'b0001, 4);
    step();
    chk("rm_req", 8'(cap_req), 8'b0001);
    step();
    chk("rm_beat1", 8'(cap_pop), 8'b0001);
    rst_req = 1'b0;
    step();
    chk("rm_busy", 8'(cap_busy), 8'd0);
    chk("rm_pop", 8'(cap_pop), 8'd0);
    chk("rm_xfer", 8'(cap_xfer), 8'd0);
    chk("rm_req_rst", 8'(cap_req), 8'd0);
    step();
    rst_req = 1'b1;
    step();
    chk("rm_rereq", 8'(cap_req), 8'b0001);
    step();
    chk("rm_rebusy", 8'(cap_busy), 8'b0001);
    chk("rm_repop", 8'(cap_pop), 8'b0001);
    drain();

    // Randomized traffic against the model.
    rnd_mode = 1;
    for (int n = 0; n < 3000; n++) begin
      for (int j = 0; j < 4; j++) begin
        rdy[j]         = ($urandom_range(0, 99) < 85);
        grant_allow[j] = ($urandom_range(0, 3) != 0);
      end
      spur    = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
      rst_req = ($urandom_range(0, 499) != 0);
      step();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
